// File: rtl/rx_slicer_agc.sv
// rx_slicer_agc: 4-PAM symbol decision with block-averaged amplitude reference.
// Takes one sample per symbol from the 4x oversampled stream, slices it against a reference
// level that tracks mean |x| over 2^LOG2_AVG symbols, and reports slicer error and lock.
// Optional feature: define RX_SLICER_MER_EN to enable the block-averaged err^2 output err_pwr.
// Symbol level constants normally come from defines.vh; fallbacks are provided below.

`ifndef SYMBOL_P2
`define SYMBOL_P2 18'sd3
`endif
`ifndef SYMBOL_P1
`define SYMBOL_P1 18'sd1
`endif
`ifndef SYMBOL_N1
`define SYMBOL_N1 -18'sd1
`endif
`ifndef SYMBOL_N2
`define SYMBOL_N2 -18'sd3
`endif

module rx_slicer_agc #(
    parameter int                     IN_W         = 18,
    parameter int                     LOG2_AVG     = 7,
    parameter logic [1:0]             SAMPLE_PHASE = 2'd0,
    parameter logic signed [IN_W-1:0] REF_INIT     = 18'sd8192
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sam_clk_en,
    input  logic [1:0]               phase4,
    input  logic                     ref_hold,
    input  logic signed [IN_W-1:0]   in,
    output logic                     sym_valid,
    output logic [1:0]               sym_idx,
    output logic signed [17:0]       sym_out,
    output logic signed [IN_W-1:0]   err,
    output logic signed [IN_W-1:0]   ref_level,
    output logic                     locked,
    output logic [2*IN_W-1:0]        err_pwr
);

    localparam int EW = IN_W + 2;
    localparam int AW = IN_W + LOG2_AVG;
    localparam logic signed [EW-1:0] SAT_HI = EW'((2 ** (IN_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-(2 ** (IN_W - 1)));

    typedef enum logic [0:0] {StAcq, StTrack} state_e;

    state_e                  state_q, state_d;
    logic signed [IN_W-1:0]  x_q;
    logic                    cap_q;
    logic                    sym_valid_q;
    logic [1:0]              idx_q, idx_d;
    logic signed [17:0]      sym_q, sym_d;
    logic signed [IN_W-1:0]  err_q, err_d;
    logic signed [IN_W-1:0]  ref_q;
    logic [AW-1:0]           acc_q, acc_sum;
    logic [LOG2_AVG-1:0]     cnt_q;
    logic [IN_W-1:0]         ax;
    logic signed [EW-1:0]    xe, refe, half, recon, diff;
    logic signed [IN_W-1:0]  new_ref;
    logic                    block_end, degen;

    // Sample capture at the symbol-centre phase; cap_q schedules the decision one clk later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            cap_q <= 1'b0;
        end else begin
            cap_q <= sam_clk_en && (phase4 == SAMPLE_PHASE);
            if (sam_clk_en && (phase4 == SAMPLE_PHASE)) x_q <= in;
        end
    end

    // Magnitude with the most-negative code clamped to the largest positive value
    always_comb begin
        ax = x_q;
        if (x_q == SAT_LO[IN_W-1:0]) ax = SAT_HI[IN_W-1:0];
        else if (x_q < 0)           ax = -x_q;
    end

    // Slicer and error, evaluated at IN_W+2 bits so 1.5*ref cannot overflow
    always_comb begin
        xe    = {{2{x_q[IN_W-1]}}, x_q};
        refe  = {{2{ref_q[IN_W-1]}}, ref_q};
        half  = refe >>> 1;
        idx_d = 2'b00;
        sym_d = `SYMBOL_N2;
        recon = -(refe + half);
        if (xe >= refe) begin
            idx_d = 2'b10;
            sym_d = `SYMBOL_P2;
            recon = refe + half;
        end else if (xe >= 0) begin
            idx_d = 2'b11;
            sym_d = `SYMBOL_P1;
            recon = half;
        end else if (xe >= -refe) begin
            idx_d = 2'b01;
            sym_d = `SYMBOL_N1;
            recon = -half;
        end
        diff = xe - recon;
        if (diff > SAT_HI)      err_d = SAT_HI[IN_W-1:0];
        else if (diff < SAT_LO) err_d = SAT_LO[IN_W-1:0];
        else                    err_d = diff[IN_W-1:0];
    end

    // Block-average arithmetic; the block ends on the decision that wraps the counter
    always_comb begin
        acc_sum   = acc_q + AW'(ax);
        new_ref   = acc_sum[AW-1:LOG2_AVG];
        degen     = new_ref < 2;
        block_end = cap_q && (&cnt_q);
    end

    // Registered decision outputs; sym_valid pulses once per decision regardless of state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_valid_q <= 1'b0;
            idx_q       <= '0;
            sym_q       <= '0;
            err_q       <= '0;
        end else begin
            sym_valid_q <= cap_q;
            if (cap_q) begin
                idx_q <= idx_d;
                sym_q <= sym_d;
                err_q <= err_d;
            end
        end
    end

    // Accumulator, symbol counter and reference update; ref_hold gates only the update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ref_q <= REF_INIT;
        end else if (cap_q) begin
            cnt_q <= cnt_q + LOG2_AVG'(1);
            if (block_end) begin
                acc_q <= '0;
                if (!ref_hold) ref_q <= degen ? REF_INIT : new_ref;
            end else begin
                acc_q <= acc_sum;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StAcq;
        else          state_q <= state_d;
    end

    // FSM next state: any block end locks, except a degenerate reference update
    always_comb begin
        state_d = state_q;
        if (block_end) begin
            if (!ref_hold && degen) state_d = StAcq;
            else                    state_d = StTrack;
        end
    end

    // FSM outputs
    always_comb begin
        locked = (state_q == StTrack);
    end

`ifdef RX_SLICER_MER_EN
    logic signed [2*IN_W-1:0] sq_s;
    logic [2*IN_W-1:0]        esum_q, esum_sat, pwr_q;
    logic [2*IN_W:0]          esum_add;

    // Saturating sum of err^2 across the block
    always_comb begin
        sq_s     = err_d * err_d;
        esum_add = {1'b0, esum_q} + {1'b0, sq_s};
        esum_sat = esum_add[2*IN_W] ? '1 : esum_add[2*IN_W-1:0];
    end

    // Error power register, published at each block end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            esum_q <= '0;
            pwr_q  <= '0;
        end else if (cap_q) begin
            if (block_end) begin
                esum_q <= '0;
                pwr_q  <= esum_sat >> LOG2_AVG;
            end else begin
                esum_q <= esum_sat;
            end
        end
    end

    assign err_pwr = pwr_q;
`else
    assign err_pwr = '0;
`endif

    assign sym_valid = sym_valid_q;
    assign sym_idx   = idx_q;
    assign sym_out   = sym_q;
    assign err       = err_q;
    assign ref_level = ref_q;

endmodule
